// File: rtl/tile_scheduler_if.sv
// tile_scheduler_if: handshake bundle between the tile scheduler and its
// environment (load/store buffers, systolic array, top-level control).
// The scheduler takes the master modport; the environment takes slave.
interface tile_scheduler_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] tile_i;
  logic [IDX_W-1:0] tile_j;
  logic [IDX_W-1:0] tile_k;
  logic             ld_req;
  logic             ld_ack;
  logic             sa_start;
  logic             sa_acc_clear;
  logic             sa_done;
  logic             st_req;
  logic             st_ack;
  logic [15:0]      cyc_cnt;

  modport master (
    input  start, ld_ack, sa_done, st_ack,
    output busy, done, tile_i, tile_j, tile_k, ld_req,
           sa_start, sa_acc_clear, st_req, cyc_cnt
  );

  modport slave (
    output start, ld_ack, sa_done, st_ack,
    input  busy, done, tile_i, tile_j, tile_k, ld_req,
           sa_start, sa_acc_clear, st_req, cyc_cnt
  );
endinterface

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks a blocked matrix product. For each output tile
// (i, j) it steps through reduction tiles k: load operands, pulse the
// systolic array, wait for completion; then it stores the output tile.
// Loop order is i outer, j middle, k inner.
// Optional feature: define TILE_SCHED_CYCLE_CNT_EN to build the saturating
// busy-cycle counter on cyc_cnt; otherwise cyc_cnt is tied to zero.
module tile_scheduler #(
  parameter int M_T   = 2,
  parameter int N_T   = 2,
  parameter int P_T   = 2,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  tile_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(M_T - 1);
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N_T - 1);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(P_T - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           state;
  logic [IDX_W-1:0] i_q;
  logic [IDX_W-1:0] j_q;
  logic [IDX_W-1:0] k_q;
  logic             busy_q;
  logic             done_q;
  logic             ld_req_q;
  logic             sa_start_q;
  logic             sa_clr_q;
  logic             st_req_q;

  // Sequencer: state, tile indices and every handshake output are registered
  // together, so outputs depend only on flops and never on same-cycle inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_req_q   <= 1'b0;
      sa_start_q <= 1'b0;
      sa_clr_q   <= 1'b0;
      st_req_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_LOAD;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            busy_q   <= 1'b1;
            ld_req_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.ld_ack) begin
            state      <= S_RUN;
            ld_req_q   <= 1'b0;
            sa_start_q <= 1'b1;
            sa_clr_q   <= (k_q == '0);
          end
        end
        S_RUN: begin
          state      <= S_WAIT;
          sa_start_q <= 1'b0;
          sa_clr_q   <= 1'b0;
        end
        S_WAIT: begin
          if (bus.sa_done) begin
            if (k_q != K_LAST) begin
              k_q      <= k_q + IDX_ONE;
              state    <= S_LOAD;
              ld_req_q <= 1'b1;
            end else begin
              state    <= S_STORE;
              st_req_q <= 1'b1;
            end
          end
        end
        S_STORE: begin
          if (bus.st_ack) begin
            st_req_q <= 1'b0;
            k_q      <= '0;
            if (i_q == I_LAST && j_q == J_LAST) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              if (j_q == J_LAST) begin
                j_q <= '0;
                i_q <= i_q + IDX_ONE;
              end else begin
                j_q <= j_q + IDX_ONE;
              end
              state    <= S_LOAD;
              ld_req_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          ld_req_q   <= 1'b0;
          sa_start_q <= 1'b0;
          sa_clr_q   <= 1'b0;
          st_req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.ld_req       = ld_req_q;
  assign bus.sa_start     = sa_start_q;
  assign bus.sa_acc_clear = sa_clr_q;
  assign bus.st_req       = st_req_q;
  assign bus.tile_i       = i_q;
  assign bus.tile_j       = j_q;
  assign bus.tile_k       = k_q;

`ifdef TILE_SCHED_CYCLE_CNT_EN
  logic [15:0] cyc_cnt_q;

  // Busy-cycle counter: cleared on an accepted start, counts every busy
  // cycle, saturates at all-ones and holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= '0;
    end else if (state == S_IDLE && bus.start) begin
      cyc_cnt_q <= '0;
    end else if (busy_q && cyc_cnt_q != 16'hFFFF) begin
      cyc_cnt_q <= cyc_cnt_q + 16'd1;
    end
  end

  assign bus.cyc_cnt = cyc_cnt_q;
`else
  assign bus.cyc_cnt = 16'd0;
`endif

endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

Sequencer that drives the systolic-array multiplier through a blocked matrix product. It walks output tiles (i, j) and, for each, the reduction tiles k. For every step it requests operand-tile loads, pulses the array start, and waits for array completion; it then requests a store of the finished output tile. It sits between the top-level load/store buffers and the systolic array, replacing ad-hoc SPLIT/COMPUTE/STORE sequencing.

## Interface
Parameters:
- M_T, 2, number of row tiles of A / result (≥1)
- N_T, 2, number of column tiles of B / result (≥1)
- P_T, 2, number of reduction tiles (≥1)
- IDX_W, 4, width of each tile-index output; must hold max(M_T, N_T, P_T)-1

Ports (reset is synchronous and active-high, on `rst`; single clock `clk`):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin a full product; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when the last tile is stored
- tile_i, tile_j, tile_k  out  IDX_W each  current tile indices; stable from LOAD through STORE
- ld_req  out  1  request load of A(i,k) and B(k,j) into array operand registers
- ld_ack  in  1  load complete
- sa_start  out  1  one-cycle start pulse to systolic array
- sa_acc_clear  out  1  valid with sa_start; 1 when tile_k==0 (array clears accumulators)
- sa_done  in  1  array finished current step
- st_req  out  1  request store of result tile (i,j)
- st_ack  in  1  store complete
- cyc_cnt  out  16  busy-cycle counter (see Configuration)

## Operation
- States: IDLE, LOAD, RUN, WAIT, STORE, DONE.
- IDLE: when start=1, go to LOAD and clear i, j, k to 0. Otherwise stay.
- LOAD: ld_req=1. When ld_ack=1 is sampled, go to RUN. A same-cycle ack is legal.
- RUN: exactly one cycle. sa_start=1 and sa_acc_clear=(k==0). Then go to WAIT.
- WAIT: stay until sa_done=1 is sampled. sa_done is ignored in every other state, including the RUN cycle.
  - If k<P_T-1: k←k+1, go to LOAD.
  - Else go to STORE.
- STORE: st_req=1. On st_ack=1:
  - k←0.
  - Advance j; on wrap from N_T-1, set j←0 and advance i.
  - If (i,j) was (M_T-1, N_T-1), go to DONE; otherwise go to LOAD.
- DONE: done=1 for one cycle, then IDLE. Indices hold their final values until the next start.
- Loop order is i outer, j middle, k inner. Total array steps = M_T·N_T·P_T; total stores = M_T·N_T.
- ld_req, sa_start, st_req, done and busy are decoded from registered state only (no combinational input-to-output paths).
- start while busy is ignored. ld_ack/st_ack outside LOAD/STORE are ignored.

## Timing
- Reset values: busy=0, done=0, ld_req=0, sa_start=0, sa_acc_clear=0, st_req=0, tile_i/j/k=0, cyc_cnt=0. State returns to IDLE.
- Reset mid-operation aborts immediately; there is no pending store or done. The next start restarts at tile (0,0,0).
- start accepted in cycle T → LOAD (ld_req, busy) visible in T+1.
- Minimum per k-step is 3 cycles (LOAD with immediate ack, RUN, WAIT with sa_done in the first WAIT cycle). Minimum per store is 1 cycle.
- Minimum total busy cycles = 3·M_T·N_T·P_T + M_T·N_T + 1.
- No timeouts: the handshake wait states hold indefinitely.

## Configuration
- TILE_SCHED_CYCLE_CNT_EN defined:
  - cyc_cnt clears to 0 when start is accepted.
  - It increments every cycle busy=1 and saturates at 16'hFFFF.
  - It holds its value after DONE until the next accepted start or rst.
- Undefined: cyc_cnt is tied to 16'd0 and no counter logic is present. The port still exists.

## Test plan
- Defaults, with ld_ack/st_ack tied to 1 and sa_done pulsed the cycle after sa_start → busy for exactly 29 cycles. The bench must see:
  - 8 sa_start pulses.
  - sa_acc_clear=1 on pulses 1, 3, 5, 7.
  - 4 st_req cycles at (i,j)=(0,0),(0,1),(1,0),(1,1).
  - One done pulse.
  - cyc_cnt=29 when the macro is defined, 0 when it is not.
- Stalled handshakes: ld_ack delayed 5 cycles, sa_done delayed 10 cycles, st_ack delayed 3 cycles → ld_req, WAIT and st_req hold for exactly those durations, and indices stay stable throughout.
- sa_done asserted during the RUN cycle and during LOAD → ignored. The FSM leaves WAIT only on a later sa_done.
- start re-asserted while busy, plus spurious st_ack in LOAD → no restart, and tile order is unchanged.
- rst asserted in WAIT of step (1,0,1) → all outputs 0 the next cycle. A following start begins at (0,0,0) with sa_acc_clear=1.
- M_T=1, N_T=3, P_T=1 → 3 sa_start pulses, all with acc_clear=1. Stores occur at j=0,1,2, and done follows the third st_ack by 1 cycle.
